lsu_ctrl: RTL and testbench

Load/store unit sitting directly upstream of dmem. It takes one load/store request at a time from the execute stage and decodes funct3 into dmem's dmemRW, w_en, addr and din. It splits misaligned accesses into two word transactions, then merges, aligns and sign/zero-extends the dmem read data. It returns a single response with an error flag for illegal, misaligned-disallowed or out-of-bound accesses.

---
 rtl/lsu_ctrl_if.sv | 29 ++
 rtl/lsu_ctrl.sv | 142 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Load/store unit bus bundle: execute-side request/response plus the dmem port.
// slave is the LSU's view, master is the execute stage plus dmem.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  dmemRW;
  logic [3:0]  w_en;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        outofbound;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, dout, outofbound,
    output req_ready, resp_valid, resp_rdata, resp_err, dmemRW, w_en, addr, din
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, dout, outofbound,
    input  req_ready, resp_valid, resp_rdata, resp_err, dmemRW, w_en, addr, din
  );
endinterface

// File: rtl/lsu_ctrl.sv
// One-at-a-time load/store sequencer in front of dmem; splits misaligned accesses in two.
// Response 3 cycles after accept (4 when split, 2 on early reject); req_ready only in IDLE.
module lsu_ctrl #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input logic       clk,
  input logic       rst,
  lsu_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISS0, ISS1, DONE} state_t;
  state_t state;

  logic        we_q, split_q, err_q, acc_q, oob_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [3:0]  en2_q;
  logic [31:0] din2_q, lo_q;

  logic [1:0]  rw_r;
  logic [3:0]  wen_r;
  logic [31:0] addr_r, din_r;
  logic        resp_valid_r, resp_err_r;
  logic [31:0] resp_rdata_r;

  logic [1:0]  off_in;
  logic [3:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [63:0] lane_data;
  logic        split_in, illegal_in, reject_in;

  // Lanes/data are laid out over two words: low half is the first access, high half the second.
  always_comb begin
    off_in = bus.req_addr[1:0];
    case (bus.req_funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_mask  = {4'b0000, size_mask} << off_in;
    lane_data  = {32'd0, bus.req_wdata} << {off_in, 3'b000};
    split_in   = |lane_mask[7:4];
    illegal_in = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                 (bus.req_we && bus.req_funct3[2]);
    reject_in  = illegal_in || (split_in && !ALLOW_MISALIGNED);
  end

  logic [31:0] lo_eff, hi_eff, merged, load_val;
  logic        err_fin;

  always_comb begin
    lo_eff  = split_q ? lo_q : bus.dout;
    hi_eff  = split_q ? bus.dout : 32'd0;
    merged  = 32'({hi_eff, lo_eff} >> {off_q, 3'b000});
    case (f3_q[1:0])
      2'b00:   load_val = {{24{!f3_q[2] && merged[7]}}, merged[7:0]};
      2'b01:   load_val = {{16{!f3_q[2] && merged[15]}}, merged[15:0]};
      default: load_val = merged;
    endcase
    err_fin = err_q || oob_q || (acc_q && bus.outofbound);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rw_r         <= 2'b00;
      wen_r        <= 4'd0;
      addr_r       <= 32'd0;
      din_r        <= 32'd0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      resp_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            off_q   <= off_in;
            split_q <= split_in;
            en2_q   <= lane_mask[7:4];
            din2_q  <= lane_data[63:32];
            oob_q   <= 1'b0;
            if (reject_in) begin
              err_q <= 1'b1;
              acc_q <= 1'b0;
              state <= DONE;
            end else begin
              err_q  <= 1'b0;
              acc_q  <= 1'b1;
              rw_r   <= bus.req_we ? 2'b01 : 2'b10;
              wen_r  <= bus.req_we ? lane_mask[3:0] : 4'd0;
              addr_r <= {bus.req_addr[31:2], 2'b00};
              din_r  <= bus.req_we ? lane_data[31:0] : 32'd0;
              state  <= ISS0;
            end
          end
        end
        ISS0: begin
          if (split_q) begin
            addr_r <= addr_r + 32'd4;
            wen_r  <= we_q ? en2_q : 4'd0;
            din_r  <= we_q ? din2_q : 32'd0;
            state  <= ISS1;
          end else begin
            rw_r   <= 2'b00;
            wen_r  <= 4'd0;
            addr_r <= 32'd0;
            din_r  <= 32'd0;
            state  <= DONE;
          end
        end
        ISS1: begin
          // The second access still went out even if this first one was out of bound.
          lo_q   <= bus.dout;
          oob_q  <= bus.outofbound;
          rw_r   <= 2'b00;
          wen_r  <= 4'd0;
          addr_r <= 32'd0;
          din_r  <= 32'd0;
          state  <= DONE;
        end
        DONE: begin
          resp_valid_r <= 1'b1;
          resp_err_r   <= err_fin;
          resp_rdata_r <= (err_fin || we_q) ? 32'd0 : load_val;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.dmemRW     = rw_r;
  assign bus.w_en       = wen_r;
  assign bus.addr       = addr_r;
  assign bus.din        = din_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a split-capable instance backed by a small dmem model,
// and a reject-misaligned instance with a tied-off dmem.
module tb_lsu_ctrl;
  logic clk, rst;
  lsu_ctrl_if b0();
  lsu_ctrl_if b1();

  lsu_ctrl #(.ALLOW_MISALIGNED(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  lsu_ctrl #(.ALLOW_MISALIGNED(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  rw;
    logic [3:0]  en;
    logic [31:0] a;
    logic [31:0] d;
  } acc_t;
  acc_t log0[$];
  int   n_acc1;

  // dmem model: synchronous read/write, addresses at or above 0xFFFF0000 are out of bound
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wtmp;

  function automatic logic [31:0] rdmem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'd0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      b0.dout       <= 32'd0;
      b0.outofbound <= 1'b0;
      mem[32'h00100000] = 32'h11987251;
      mem[32'h00100004] = 32'h18790475;
    end else begin
      b0.outofbound <= (b0.dmemRW != 2'b00) && (b0.addr >= 32'hFFFF0000);
      if (b0.dmemRW == 2'b10) begin
        b0.dout <= rdmem(b0.addr);
      end else if (b0.dmemRW == 2'b01) begin
        wtmp = rdmem(b0.addr);
        for (int i = 0; i < 4; i++)
          if (b0.w_en[i]) wtmp[8*i +: 8] = b0.din[8*i +: 8];
        mem[b0.addr] = wtmp;
      end
    end
  end

  assign b1.dout       = 32'd0;
  assign b1.outofbound = 1'b0;

  always @(negedge clk) begin
    if (b0.dmemRW != 2'b00) log0.push_back('{b0.dmemRW, b0.w_en, b0.addr, b0.din});
    if (b1.dmemRW != 2'b00) n_acc1++;
  end

  int          r_lat;
  logic [31:0] r_data;
  logic        r_err;

  // Drives the request now; it is accepted on the next rising edge.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int lat;
    chk("req_ready", {31'd0, b0.req_ready}, 32'd1);
    log0.delete();
    b0.req_valid  = 1'b1;
    b0.req_we     = we;
    b0.req_funct3 = f3;
    b0.req_addr   = a;
    b0.req_wdata  = d;
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
    chk("resp_pulse", {31'd0, b0.resp_valid}, 32'd0);
    lat = 1;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!b0.resp_valid && lat < 20);
    r_lat  = lat;
    r_data = b0.resp_rdata;
    r_err  = b0.resp_err;
  endtask

  task automatic send1(input logic [2:0] f3, input logic [31:0] a);
    int lat;
    chk("b1.req_ready", {31'd0, b1.req_ready}, 32'd1);
    n_acc1 = 0;
    b1.req_valid  = 1'b1;
    b1.req_we     = 1'b0;
    b1.req_funct3 = f3;
    b1.req_addr   = a;
    b1.req_wdata  = 32'd0;
    @(posedge clk); #1;
    b1.req_valid = 1'b0;
    lat = 1;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!b1.resp_valid && lat < 20);
    r_lat  = lat;
    r_data = b1.resp_rdata;
    r_err  = b1.resp_err;
  endtask

  task automatic exp_resp(input string tag, input int lat, input logic [31:0] data, input logic err);
    chk({tag, ".lat"},   r_lat, lat);
    chk({tag, ".rdata"}, r_data, data);
    chk({tag, ".err"},   {31'd0, r_err}, {31'd0, err});
  endtask

  task automatic exp_acc(input string tag, input int idx, input logic [1:0] rw,
                         input logic [3:0] en, input logic [31:0] a, input logic [31:0] d);
    acc_t e;
    e = (idx < log0.size()) ? log0[idx] : '1;
    chk({tag, ".rw"},   {30'd0, e.rw}, {30'd0, rw});
    chk({tag, ".w_en"}, {28'd0, e.en}, {28'd0, en});
    chk({tag, ".addr"}, e.a, a);
    chk({tag, ".din"},  e.d, d);
  endtask

  int seen;

  initial begin
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_funct3 = 3'd0; b0.req_addr = 32'd0; b0.req_wdata = 32'd0;
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_funct3 = 3'd0; b1.req_addr = 32'd0; b1.req_wdata = 32'd0;
    n_acc1 = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.dmemRW",     {30'd0, b0.dmemRW}, 32'd0);
    chk("rst.w_en",       {28'd0, b0.w_en}, 32'd0);
    chk("rst.addr",       b0.addr, 32'd0);
    chk("rst.din",        b0.din, 32'd0);
    chk("rst.resp_valid", {31'd0, b0.resp_valid}, 32'd0);
    chk("rst.resp_err",   {31'd0, b0.resp_err}, 32'd0);
    chk("rst.rdata",      b0.resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Aligned and non-split loads
    send(1'b0, 3'b010, 32'h00100000, 32'd0);
    exp_resp("lw0", 3, 32'h11987251, 1'b0);
    chk("lw0.nacc", log0.size(), 1);
    exp_acc("lw0.a0", 0, 2'b10, 4'b0000, 32'h00100000, 32'd0);
    send(1'b0, 3'b000, 32'h00100002, 32'd0);
    exp_resp("lb2", 3, 32'hFFFFFF98, 1'b0);
    send(1'b0, 3'b100, 32'h00100002, 32'd0);
    exp_resp("lbu2", 3, 32'h00000098, 1'b0);
    send(1'b0, 3'b001, 32'h00100001, 32'd0);
    exp_resp("lh1", 3, 32'hFFFF9872, 1'b0);

    // Split loads
    send(1'b0, 3'b010, 32'h00100002, 32'd0);
    exp_resp("lw2", 4, 32'h04751198, 1'b0);
    chk("lw2.nacc", log0.size(), 2);
    exp_acc("lw2.a0", 0, 2'b10, 4'b0000, 32'h00100000, 32'd0);
    exp_acc("lw2.a1", 1, 2'b10, 4'b0000, 32'h00100004, 32'd0);
    send(1'b0, 3'b101, 32'h00100003, 32'd0);
    exp_resp("lhu3", 4, 32'h00007511, 1'b0);

    // Stores, then read back the merged bytes
    send(1'b1, 3'b010, 32'h80000001, 32'h20221118);
    exp_resp("sw1", 4, 32'd0, 1'b0);
    exp_acc("sw1.a0", 0, 2'b01, 4'b1110, 32'h80000000, 32'h22111800);
    exp_acc("sw1.a1", 1, 2'b01, 4'b0001, 32'h80000004, 32'h00000020);
    send(1'b1, 3'b001, 32'h80000002, 32'h20221118);
    exp_resp("sh2", 3, 32'd0, 1'b0);
    exp_acc("sh2.a0", 0, 2'b01, 4'b1100, 32'h80000000, 32'h11180000);
    send(1'b0, 3'b010, 32'h80000000, 32'd0);
    exp_resp("rb0", 3, 32'h11181800, 1'b0);
    send(1'b0, 3'b010, 32'h80000001, 32'd0);
    exp_resp("rb1", 4, 32'h20111818, 1'b0);

    // Illegal encodings never reach dmem
    send(1'b0, 3'b011, 32'h00100000, 32'd0);
    exp_resp("ld", 2, 32'd0, 1'b1);
    chk("ld.nacc", log0.size(), 0);
    send(1'b1, 3'b100, 32'h00100000, 32'h12345678);
    exp_resp("sbu", 2, 32'd0, 1'b1);
    chk("sbu.nacc", log0.size(), 0);

    // Out-of-bound, including a split that wraps to address 0
    send(1'b0, 3'b010, 32'hFFFF0000, 32'd0);
    exp_resp("oob", 3, 32'd0, 1'b1);
    send(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0);
    exp_resp("wrap", 4, 32'd0, 1'b1);
    exp_acc("wrap.a0", 0, 2'b10, 4'b0000, 32'hFFFFFFFC, 32'd0);
    exp_acc("wrap.a1", 1, 2'b10, 4'b0000, 32'h00000000, 32'd0);

    // Reject-misaligned instance
    send1(3'b010, 32'h00100002);
    exp_resp("nomis", 2, 32'd0, 1'b1);
    chk("nomis.nacc", n_acc1, 0);
    send1(3'b010, 32'h00100000);
    exp_resp("nomis_al", 3, 32'd0, 1'b0);
    chk("nomis_al.nacc", n_acc1, 1);

    // Reset in ISS1 drops the request
    chk("rstiss.ready", {31'd0, b0.req_ready}, 32'd1);
    b0.req_valid = 1'b1; b0.req_we = 1'b0; b0.req_funct3 = 3'b010;
    b0.req_addr = 32'h00100002; b0.req_wdata = 32'd0;
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
    chk("rstiss.iss0_addr", b0.addr, 32'h00100000);
    @(posedge clk); #1;
    chk("rstiss.iss1_addr", b0.addr, 32'h00100004);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstiss.dmemRW",     {30'd0, b0.dmemRW}, 32'd0);
    chk("rstiss.addr",       b0.addr, 32'd0);
    chk("rstiss.rdata",      b0.resp_rdata, 32'd0);
    chk("rstiss.ready",      {31'd0, b0.req_ready}, 32'd1);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (b0.resp_valid) seen++;
    end
    chk("rstiss.noresp", seen, 0);

    // Back-to-back after reset
    send(1'b0, 3'b010, 32'h00100004, 32'd0);
    exp_resp("b2b0", 3, 32'h18790475, 1'b0);
    send(1'b0, 3'b000, 32'h00100007, 32'd0);
    exp_resp("b2b1", 3, 32'h00000018, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
